// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  // Destination info of the three downstream stages, as seen by forwarding.
  typedef struct packed {
    logic [REG_W-1:0] exe_rd;
    logic             exe_regwrite;
    logic             exe_memread;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic [REG_W-1:0] wb_rd;
    logic             wb_regwrite;
  } stage_info_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding source select for one ID-stage source register.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  stage_info_t      stages,
  output fwd_sel_t         sel
);

  // Youngest matching producer wins; loads in EXE have no result yet.
  always_comb begin
    sel = FWD_RF;
    if (use_src && (src != REG_ZERO)) begin
      if (stages.exe_regwrite && !stages.exe_memread && (stages.exe_rd == src)) begin
        sel = FWD_EXE;
      end else if (stages.mem_regwrite && (stages.mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (stages.wb_regwrite && (stages.wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, memory freeze,
// timeout halt and saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] exe_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             exe_regwrite,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic             exe_memread,
  input  logic             mem_memop,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  stage_info_t       stages;
  fwd_sel_t          sel_a;
  fwd_sel_t          sel_b;
  logic              load_use;
  logic              mem_stall;

  assign stages = '{
    exe_rd:       exe_rd,
    exe_regwrite: exe_regwrite,
    exe_memread:  exe_memread,
    mem_rd:       mem_rd,
    mem_regwrite: mem_regwrite,
    wb_rd:        wb_rd,
    wb_regwrite:  wb_regwrite
  };

  fwd_select u_fwd_a (
    .src     (rs1),
    .use_src (use_rs1),
    .stages  (stages),
    .sel     (sel_a)
  );

  fwd_select u_fwd_b (
    .src     (rs2),
    .use_src (use_rs2),
    .stages  (stages),
    .sel     (sel_b)
  );

  // ID needs a load result that is still in EXE.
  assign load_use = exe_memread && (exe_rd != REG_ZERO) &&
                    ((use_rs1 && (rs1 == exe_rd)) || (use_rs2 && (rs2 == exe_rd)));

  assign mem_stall = mem_memop && !mem_ready;

  // Next state and pipeline controls; freeze > load-use > branch.
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    fwd_a         = 2'(sel_a);
    fwd_b         = 2'(sel_b);

    if (reset) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_exe_en     = 1'b0;
      exe_mem_en    = 1'b0;
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
      fwd_a         = 2'(FWD_RF);
      fwd_b         = 2'(FWD_RF);
    end else begin
      case (state)
        HALT: begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_exe_en     = 1'b0;
          exe_mem_en    = 1'b0;
          if_id_flush   = 1'b1;
          id_exe_bubble = 1'b1;
          mem_wb_bubble = 1'b1;
          halted        = 1'b1;
        end
        default: begin
          if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_en    = 1'b0;
            mem_wb_bubble = 1'b1;
            if (state != MEM_WAIT) begin
              state_nxt = MEM_WAIT;
              wait_nxt  = WAIT_W'(1);
            end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
              state_nxt = HALT;
            end else begin
              wait_nxt = wait_cnt + WAIT_W'(1);
            end
          end else begin
            // Memory done (or idle): behave as RUN this cycle.
            state_nxt = RUN;
            wait_nxt  = '0;
            if (load_use) begin
              pc_en         = 1'b0;
              if_id_en      = 1'b0;
              id_exe_bubble = 1'b1;
            end else if (branch_taken) begin
              if_id_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // FSM state and memory-wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
